mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one RAM port between the instruction and data caches of CPUS cores.
// Data outranks fetch, cores rotate round-robin, and an age counter promotes starved fetches.
module mem_arbiter #(
    parameter int CPUS = 2,
    parameter int IMAX = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [CPUS-1:0]    iREN,
    input  logic [CPUS-1:0]    dREN,
    input  logic [CPUS-1:0]    dWEN,
    input  logic [CPUS*32-1:0] iaddr,
    input  logic [CPUS*32-1:0] daddr,
    input  logic [CPUS*32-1:0] dstore,
    output logic [CPUS-1:0]    iwait,
    output logic [CPUS-1:0]    dwait,
    output logic [CPUS*32-1:0] iload,
    output logic [CPUS*32-1:0] dload,
    output logic               ramREN,
    output logic               ramWEN,
    output logic [31:0]        ramaddr,
    output logic [31:0]        ramstore,
    input  logic [31:0]        ramload,
    input  logic [1:0]         ramstate
);

    localparam int OW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int AW = $clog2(IMAX + 1);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic {IDLE, SERVE} state_t;
    typedef enum logic {K_I, K_D} kind_t;

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_q, rr_d;
    logic          wr_q, wr_d;
    logic          ipend_q, ipend_d;
    logic [AW-1:0] age_q, age_d;

    logic [CPUS-1:0] dreq;
    logic [OW:0]     pick_i, pick_d;
    logic            win_found;
    logic [OW-1:0]   win_idx;
    kind_t           win_kind;

    int          oi;
    logic        o_iren, o_dren, o_dwen;
    logic [31:0] o_iaddr, o_daddr, o_dstore;
    logic        live, cmpl;

    // First set bit of m at or after position p; MSB of the result flags a hit.
    function automatic logic [OW:0] pick(input logic [CPUS-1:0] m,
                                         input logic [OW-1:0] p);
        logic [OW:0] r;
        int j;
        r = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            j = (int'(p) + k) % CPUS;
            if (m[j]) r = {1'b1, OW'(j)};
        end
        return r;
    endfunction

    always_comb begin
        dreq      = dREN | dWEN;
        pick_i    = pick(iREN, rr_q);
        pick_d    = pick(dreq, rr_q);
        win_found = (|iREN) | (|dreq);
        win_kind  = K_I;
        win_idx   = pick_i[OW-1:0];
        if (age_q == AW'(IMAX) && pick_i[OW]) begin
            win_kind = K_I;
            win_idx  = pick_i[OW-1:0];
        end else if (pick_d[OW]) begin
            win_kind = K_D;
            win_idx  = pick_d[OW-1:0];
        end
    end

    always_comb begin
        oi       = int'(owner_q);
        o_iren   = iREN[oi];
        o_dren   = dREN[oi];
        o_dwen   = dWEN[oi];
        o_iaddr  = iaddr[oi*32 +: 32];
        o_daddr  = daddr[oi*32 +: 32];
        o_dstore = dstore[oi*32 +: 32];
        // The granted request is still being held by its owner
        if (kind_q == K_I) live = o_iren;
        else if (wr_q)     live = o_dwen;
        else               live = o_dren;
        cmpl = (state_q == SERVE) && live && (ramstate == RAM_ACCESS);
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        kind_d  = kind_q;
        wr_d    = wr_q;
        ipend_d = ipend_q;
        rr_d    = rr_q;
        age_d   = age_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = SERVE;
                    owner_d = win_idx;
                    kind_d  = win_kind;
                    wr_d    = (win_kind == K_D) && dWEN[win_idx];
                    ipend_d = |iREN;
                end
            end
            SERVE: begin
                if (!live) begin
                    state_d = IDLE;
                end else if (cmpl) begin
                    state_d = IDLE;
                    if (owner_q == OW'(CPUS - 1)) rr_d = '0;
                    else                          rr_d = owner_q + 1'b1;
                    if (kind_q == K_I)
                        age_d = '0;
                    else if (ipend_q && age_q != AW'(IMAX))
                        age_d = age_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state_q == SERVE) begin
            if (kind_q == K_I) begin
                ramREN  = o_iren;
                ramaddr = o_iaddr;
            end else begin
                ramaddr = o_daddr;
                if (wr_q) begin
                    ramWEN   = o_dwen;
                    ramstore = o_dstore;
                end else begin
                    ramREN = o_dren;
                end
            end
        end
        if (cmpl) begin
            if (kind_q == K_I) begin
                iwait[oi]         = 1'b0;
                iload[oi*32 +: 32] = ramload;
            end else begin
                dwait[oi] = 1'b0;
                if (!wr_q) dload[oi*32 +: 32] = ramload;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            owner_q <= '0;
            kind_q  <= K_I;
            wr_q    <= 1'b0;
            ipend_q <= 1'b0;
            rr_q    <= '0;
            age_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            kind_q  <= kind_d;
            wr_q    <= wr_d;
            ipend_q <= ipend_d;
            rr_q    <= rr_d;
            age_q   <= age_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected completions are queued by the
// stimulus and popped by a monitor whenever a wait line drops.
module tb_mem_arbiter;

    logic        CLK;
    logic        RST;
    logic [1:0]  iREN, dREN, dWEN;
    logic [63:0] iaddr, daddr, dstore;
    logic [1:0]  iwait, dwait;
    logic [63:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt = 0;
    int lat = 0;

    typedef struct {
        logic [1:0]  who;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] store;
        logic [31:0] load;
    } exp_t;
    exp_t q[$];

    mem_arbiter #(.CPUS(2), .IMAX(8)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait),
        .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM: first strobe cycle FREE, then BUSY until lat cycles, then ACCESS
    always_comb begin
        ramstate = 2'd0;
        if (ramREN || ramWEN) begin
            if (cnt >= lat)    ramstate = 2'd2;
            else if (cnt == 0) ramstate = 2'd0;
            else               ramstate = 2'd1;
        end
    end
    assign ramload = (ramaddr == 32'h40) ? 32'hDEADBEEF : ramaddr + 32'h1000_0000;

    always @(posedge CLK) begin
        if (!(ramREN || ramWEN) || ramstate == 2'd2) cnt <= 0;
        else cnt <= cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic expect_tx(input logic k, input logic c, input logic [31:0] a,
                             input logic w, input logic [31:0] s, input logic [31:0] l);
        exp_t e;
        e.who   = {k, c};
        e.addr  = a;
        e.wen   = w;
        e.store = s;
        e.load  = l;
        q.push_back(e);
    endtask

    task automatic check_done(input logic k, input int c);
        exp_t e;
        logic [31:0] ld;
        ld = k ? dload[c*32 +: 32] : iload[c*32 +: 32];
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got kind=%0d core=%0d, required none", k, c);
        end else begin
            e = q.pop_front();
            chk("done_who", {30'd0, k, c[0]}, {30'd0, e.who});
            chk("done_addr", ramaddr, e.addr);
            chk("done_wen", {31'd0, ramWEN}, {31'd0, e.wen});
            chk("done_store", ramstore, e.store);
            chk("done_load", ld, e.load);
        end
    endtask

    always @(negedge CLK) begin
        for (int c = 0; c < 2; c++) begin
            if (!iwait[c]) check_done(1'b0, c);
            if (!dwait[c]) check_done(1'b1, c);
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        cyc();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        repeat (2) cyc();
        smp();
        chk("rst_iwait", {30'd0, iwait}, 32'h3);
        chk("rst_dwait", {30'd0, dwait}, 32'h3);
        chk("rst_iload", iload[31:0] | iload[63:32], 32'h0);
        chk("rst_dload", dload[31:0] | dload[63:32], 32'h0);
        chk("rst_strobes", {30'd0, ramREN, ramWEN}, 32'h0);
        chk("rst_addr", ramaddr | ramstore, 32'h0);
        cyc();
        RST = 1'b0;
        cyc();

        // single fetch with two BUSY cycles
        cyc();
        lat = 3; iREN = 2'b01; iaddr[31:0] = 32'h40;
        expect_tx(1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 32'hDEADBEEF);
        smp();
        chk("t1_c0_ren", {31'd0, ramREN}, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            smp();
            chk("t1_ren", {31'd0, ramREN}, 32'h1);
            chk("t1_addr", ramaddr, 32'h40);
            chk("t1_iwait", {31'd0, iwait[0]}, 32'h1);
        end
        smp();
        chk("t1_c4_iwait", {31'd0, iwait[0]}, 32'h0);
        chk("t1_c4_iload", iload[31:0], 32'hDEADBEEF);
        cyc();
        iREN = 2'b00;
        repeat (2) cyc();

        // data write beats a simultaneous fetch
        lat = 0; iREN = 2'b01; iaddr[31:0] = 32'h44;
        dWEN = 2'b01; daddr[31:0] = 32'h80; dstore[31:0] = 32'h5;
        expect_tx(1'b1, 1'b0, 32'h80, 1'b1, 32'h5, 32'h0);
        expect_tx(1'b0, 1'b0, 32'h44, 1'b0, 32'h0, 32'h1000_0044);
        smp();
        smp();
        chk("t2_wen", {31'd0, ramWEN}, 32'h1);
        chk("t2_store", ramstore, 32'h5);
        chk("t2_dwait", {30'd0, dwait}, 32'h2);
        cyc();
        dWEN = 2'b00;
        smp();
        chk("t2_bubble", {30'd0, ramREN, ramWEN}, 32'h0);
        smp();
        chk("t2_fetch_ren", {31'd0, ramREN}, 32'h1);
        chk("t2_fetch_addr", ramaddr, 32'h44);
        cyc();
        iREN = 2'b00;

        // round-robin data reads
        do_reset();
        cyc();
        lat = 0; dREN = 2'b11; daddr = {32'h200, 32'h100};
        for (int k = 0; k < 2; k++) begin
            expect_tx(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 32'h1000_0100);
            expect_tx(1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 32'h1000_0200);
        end
        smp();
        for (int k = 1; k <= 7; k++) begin
            smp();
            if (k % 2 == 1)
                chk("t3_grant", {30'd0, dwait}, (k % 4 == 1) ? 32'h2 : 32'h1);
            else
                chk("t3_bubble", {30'd0, dwait}, 32'h3);
        end
        cyc();
        dREN = 2'b00;

        // aging: eight data grants, then the starved fetch
        do_reset();
        cyc();
        lat = 0; dREN = 2'b01; daddr[31:0] = 32'h104;
        iREN = 2'b10; iaddr[63:32] = 32'h300;
        repeat (8) expect_tx(1'b1, 1'b0, 32'h104, 1'b0, 32'h0, 32'h1000_0104);
        expect_tx(1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 32'h1000_0300);
        smp();
        for (int k = 1; k <= 17; k++) begin
            smp();
            if (k == 16) chk("t4_bubble", {28'd0, iwait, dwait}, 32'hF);
            if (k == 17) begin
                chk("t4_iaddr", ramaddr, 32'h300);
                chk("t4_iwait", {30'd0, iwait}, 32'h1);
            end
        end
        cyc();
        dREN = 2'b00; iREN = 2'b00;

        // abort during BUSY leaves rr untouched
        do_reset();
        cyc();
        lat = 5; dREN = 2'b01; daddr[31:0] = 32'h108;
        smp();
        smp();
        chk("t5_ren", {31'd0, ramREN}, 32'h1);
        smp();
        cyc();
        dREN = 2'b00;
        smp();
        chk("t5_abort_dwait", {30'd0, dwait}, 32'h3);
        cyc();
        smp();
        chk("t5_idle_ren", {31'd0, ramREN}, 32'h0);
        cyc();
        lat = 0; dREN = 2'b11; daddr[63:32] = 32'h20C;
        expect_tx(1'b1, 1'b0, 32'h108, 1'b0, 32'h0, 32'h1000_0108);
        smp();
        smp();
        chk("t5_rr", {30'd0, dwait}, 32'h2);
        cyc();
        dREN = 2'b00;
        repeat (2) cyc();

        // reset in the middle of a grant
        lat = 5; dREN = 2'b10; daddr[63:32] = 32'h20C;
        smp();
        smp();
        chk("t6_ren", {31'd0, ramREN}, 32'h1);
        cyc();
        RST = 1'b1;
        cyc();
        RST = 1'b0; lat = 0;
        expect_tx(1'b1, 1'b1, 32'h20C, 1'b0, 32'h0, 32'h1000_020C);
        smp();
        chk("t6_rst_ren", {31'd0, ramREN}, 32'h0);
        chk("t6_rst_waits", {28'd0, iwait, dwait}, 32'hF);
        smp();
        chk("t6_regrant", {31'd0, ramREN}, 32'h1);
        cyc();
        dREN = 2'b00;

        repeat (3) cyc();
        chk("queue_drained", q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
